// File: rtl/spi_slave_cfg_pkg.sv
// Shared types and defaults for the SPI slave configuration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sequencer state enum, register word width, default queue depth,
//   retry limit and response timeout.
package spi_slave_cfg_pkg;

  localparam int reg_din_width_c = 8;
  localparam int qdepth_def_c    = 4;
  localparam int max_retry_def_c = 3;
  localparam int timeout_def_c   = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    ISSUE     = 2'd2,
    WAIT_RESP = 2'd3
  } cfg_seq_state_t;

endpackage

// File: rtl/spi_cfg_req_fifo.sv
// Request queue: synchronous DEPTH x W FIFO with registered occupancy.
// Latency: a pushed word is visible at pop_dat one cycle after the push.
// Backpressure: push while full is dropped and ovf pulses the next cycle.
// Ports: clk/rst (async, active-high); push/push_dat write side;
//   pop/pop_dat read side (pop_dat is the head, valid while !empty);
//   full/empty status from the registered count; ovf drop pulse.
module spi_cfg_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push_ok, pop_ok;

  // Full is taken from the registered count, so a pop in the same cycle
  // does not make room for a push.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign ovf     = ovf_q;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = push && full;
    // Pointers are exactly AW bits wide, so the increment wraps mod DEPTH.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/spi_slave_cfg_seq.sv
// Config sequencer: queues host register words and issues them to the SPI
//   slave between transactions, retrying on error/timeout.
// Latency: reg_din_val rises 2 cycles after a push when the slave is not busy.
// Backpressure: cfg_full stalls the host (overflowing pushes drop, cfg_ovf
//   pulses); issue waits for !spi_busy; the queue head pops only once resolved.
// Ports: clk, rst (async, active-high); cfg_data/cfg_wr host push with
//   cfg_full/cfg_empty status; spi_busy from the core; reg_din/reg_din_val
//   issue to the slave; reg_ack/reg_err slave response; cfg_done/cfg_fail/
//   cfg_ovf one-cycle event pulses; idle when IDLE and queue empty.
// Build option SPI_CFG_SEQ_STATS_EN adds saturating stat_done_cnt,
//   stat_fail_cnt and stat_retry_cnt outputs.
module spi_slave_cfg_seq
  import spi_slave_cfg_pkg::*;
#(
  parameter int REG_W       = reg_din_width_c,
  parameter int QDEPTH      = qdepth_def_c,
  parameter int MAX_RETRY   = max_retry_def_c,
  parameter int TIMEOUT_CYC = timeout_def_c
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] cfg_data,
  input  logic             cfg_wr,
  output logic             cfg_full,
  output logic             cfg_empty,
  input  logic             spi_busy,
  output logic [REG_W-1:0] reg_din,
  output logic             reg_din_val,
  input  logic             reg_ack,
  input  logic             reg_err,
  output logic             cfg_done,
  output logic             cfg_fail,
  output logic             cfg_ovf,
  output logic             idle
`ifdef SPI_CFG_SEQ_STATS_EN
  ,
  output logic [15:0]      stat_done_cnt,
  output logic [15:0]      stat_fail_cnt,
  output logic [15:0]      stat_retry_cnt
`endif
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYC - 1);

  cfg_seq_state_t   state_q, state_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [REG_W-1:0] reg_din_q, reg_din_d;
  logic             reg_din_val_q, reg_din_val_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             retry_evt;

  logic             fifo_pop;
  logic [REG_W-1:0] head_dat;
  logic             fifo_full, fifo_empty, fifo_ovf;

  spi_cfg_req_fifo #(
    .W     (REG_W),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cfg_wr),
    .push_dat (cfg_data),
    .pop      (fifo_pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ovf      (fifo_ovf)
  );

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    timer_d       = timer_q;
    reg_din_d     = reg_din_q;
    reg_din_val_d = 1'b0;
    done_d        = 1'b0;
    fail_d        = 1'b0;
    fifo_pop      = 1'b0;
    retry_evt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Load the word on the way into ISSUE so the strobe and data are
        // registered outputs during the ISSUE cycle.
        if (!spi_busy) begin
          state_d       = ISSUE;
          reg_din_d     = head_dat;
          reg_din_val_d = 1'b1;
          timer_d       = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT_RESP;
        timer_d = '0;
      end
      WAIT_RESP: begin
        timer_d = timer_q + 1'b1;
        if (reg_ack && !reg_err) begin
          fifo_pop = 1'b1;
          done_d   = 1'b1;
          retry_d  = '0;
          state_d  = IDLE;
        end else if (reg_err || (timer_q == TIMER_LAST)) begin
          // Error wins over a simultaneous ack; a timeout counts as an error.
          if (retry_q < RETRY_LIMIT) begin
            retry_d   = retry_q + 1'b1;
            retry_evt = 1'b1;
            state_d   = WAIT_BUSY;
          end else begin
            fifo_pop = 1'b1;
            fail_d   = 1'b1;
            retry_d  = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      retry_q       <= '0;
      timer_q       <= '0;
      reg_din_q     <= '0;
      reg_din_val_q <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      reg_din_q     <= reg_din_d;
      reg_din_val_q <= reg_din_val_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  assign reg_din     = reg_din_q;
  assign reg_din_val = reg_din_val_q;
  assign cfg_done    = done_q;
  assign cfg_fail    = fail_q;
  assign cfg_ovf     = fifo_ovf;
  assign cfg_full    = fifo_full;
  assign cfg_empty   = fifo_empty;
  assign idle        = (state_q == IDLE) && fifo_empty;

`ifdef SPI_CFG_SEQ_STATS_EN
  logic [15:0] stat_done_q, stat_done_d;
  logic [15:0] stat_fail_q, stat_fail_d;
  logic [15:0] stat_retry_q, stat_retry_d;

  // Counters hold at all-ones rather than wrapping.
  always_comb begin
    stat_done_d  = stat_done_q;
    stat_fail_d  = stat_fail_q;
    stat_retry_d = stat_retry_q;
    if (done_d && (stat_done_q != 16'hFFFF))     stat_done_d  = stat_done_q + 16'd1;
    if (fail_d && (stat_fail_q != 16'hFFFF))     stat_fail_d  = stat_fail_q + 16'd1;
    if (retry_evt && (stat_retry_q != 16'hFFFF)) stat_retry_d = stat_retry_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done_q  <= '0;
      stat_fail_q  <= '0;
      stat_retry_q <= '0;
    end else begin
      stat_done_q  <= stat_done_d;
      stat_fail_q  <= stat_fail_d;
      stat_retry_q <= stat_retry_d;
    end
  end

  assign stat_done_cnt  = stat_done_q;
  assign stat_fail_cnt  = stat_fail_q;
  assign stat_retry_cnt = stat_retry_q;
`endif

endmodule

// File: tb/tb_spi_slave_cfg_seq.sv
// Bench for spi_slave_cfg_seq: randomized host pushes and slave responses
//   checked against a transaction-level queue model with per-word attempt counts.
// Timing rule used by the model: a failure/ack seen in cycle F gives its
//   result pulse in F+1; a retry issues in F+2, the next queued word in F+3.
module tb_spi_slave_cfg_seq;

  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_data;
  logic       cfg_wr;
  logic       cfg_full, cfg_empty;
  logic       spi_busy;
  logic [7:0] reg_din;
  logic       reg_din_val;
  logic       reg_ack, reg_err;
  logic       cfg_done, cfg_fail, cfg_ovf, idle;
`ifdef SPI_CFG_SEQ_STATS_EN
  logic [15:0] stat_done_cnt, stat_fail_cnt, stat_retry_cnt;
`endif

  always #5 clk = ~clk;

  spi_slave_cfg_seq dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_data    (cfg_data),
    .cfg_wr      (cfg_wr),
    .cfg_full    (cfg_full),
    .cfg_empty   (cfg_empty),
    .spi_busy    (spi_busy),
    .reg_din     (reg_din),
    .reg_din_val (reg_din_val),
    .reg_ack     (reg_ack),
    .reg_err     (reg_err),
    .cfg_done    (cfg_done),
    .cfg_fail    (cfg_fail),
    .cfg_ovf     (cfg_ovf),
    .idle        (idle)
`ifdef SPI_CFG_SEQ_STATS_EN
    ,
    .stat_done_cnt  (stat_done_cnt),
    .stat_fail_cnt  (stat_fail_cnt),
    .stat_retry_cnt (stat_retry_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int stray = 0;
  int exp_done  = 0;
  int exp_fail  = 0;
  int exp_retry = 0;
  logic [7:0] mq[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A cycle in which no strobe or event pulse is allowed.
  task automatic quiet_tick();
    tick();
    stray += int'(reg_din_val) + int'(cfg_done) + int'(cfg_fail) + int'(cfg_ovf);
  endtask

  task automatic run_scenario(input int s);
    int n, hold, kind, d, q, attempts;
    logic [7:0] w, issued;
    n = (s == 0) ? 5 : $urandom_range(1, 6);
    spi_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      cfg_data = w;
      cfg_wr = 1'b1;
      tick();
      check_eq("ovf", int'(cfg_ovf), (mq.size() >= 4) ? 1 : 0);
      if (mq.size() < 4) mq.push_back(w);
      check_eq("full", int'(cfg_full), (mq.size() == 4) ? 1 : 0);
    end
    cfg_wr = 1'b0;
    hold = $urandom_range(3, 20);
    stray = 0;
    repeat (hold) quiet_tick();
    check_eq("busy_hold_quiet", stray, 0);
    spi_busy = 1'b0;
    tick();
    check_eq("issue_after_busy", int'(reg_din_val), 1);
    attempts = 0;
    while (mq.size() > 0) begin
      issued = mq[0];
      check_eq("reg_din", int'(reg_din), int'(issued));
      attempts++;
      // Scenarios 0..3 force ack / err / ack+err / silent on every attempt.
      kind = (s < 4) ? s : $urandom_range(0, 3);
      d = $urandom_range(0, 6);
      q = (kind == 3) ? TIMEOUT : d + 1;
      stray = 0;
      for (int j = 0; j < q; j++) begin
        quiet_tick();
        spi_busy = (j < q - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (j == q - 1) begin
          reg_ack = (kind == 0) || (kind == 2);
          reg_err = (kind == 1) || (kind == 2);
        end
      end
      tick();
      reg_ack = 1'b0;
      reg_err = 1'b0;
      check_eq("resp_quiet", stray, 0);
      check_eq("reg_din_hold", int'(reg_din), int'(issued));
      if (kind == 0) begin
        check_eq("done", int'(cfg_done), 1);
        check_eq("no_fail", int'(cfg_fail), 0);
        void'(mq.pop_front());
        attempts = 0;
        exp_done++;
      end else if (attempts <= MAX_RETRY) begin
        check_eq("retry_no_done", int'(cfg_done), 0);
        check_eq("retry_no_fail", int'(cfg_fail), 0);
        exp_retry++;
        tick();
        check_eq("retry_issue", int'(reg_din_val), 1);
        continue;
      end else begin
        check_eq("fail", int'(cfg_fail), 1);
        check_eq("fail_no_done", int'(cfg_done), 0);
        void'(mq.pop_front());
        attempts = 0;
        exp_fail++;
      end
      if (mq.size() > 0) begin
        stray = 0;
        quiet_tick();
        check_eq("gap_quiet", stray, 0);
        tick();
        check_eq("next_issue", int'(reg_din_val), 1);
      end else begin
        check_eq("idle_end", int'(idle), 1);
        check_eq("empty_end", int'(cfg_empty), 1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_reg_din"}, int'(reg_din), 0);
    check_eq({tag, "_val"}, int'(reg_din_val), 0);
    check_eq({tag, "_pulses"}, int'(cfg_done) + int'(cfg_fail) + int'(cfg_ovf), 0);
    check_eq({tag, "_full"}, int'(cfg_full), 0);
    check_eq({tag, "_empty"}, int'(cfg_empty), 1);
    check_eq({tag, "_idle"}, int'(idle), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_wr = 1'b0;
    cfg_data = 8'h00;
    spi_busy = 1'b1;
    reg_ack = 1'b0;
    reg_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    tick();

    for (int s = 0; s < 12; s++) run_scenario(s);

`ifdef SPI_CFG_SEQ_STATS_EN
    check_eq("stat_done", int'(stat_done_cnt), exp_done);
    check_eq("stat_fail", int'(stat_fail_cnt), exp_fail);
    check_eq("stat_retry", int'(stat_retry_cnt), exp_retry);
`endif

    // Push with the slave idle: strobe 2 cycles after the push edge, then
    // reset in WAIT_RESP and present a late ack.
    spi_busy = 1'b0;
    cfg_data = 8'hA5;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    tick();
    tick();
    check_eq("latency_issue", int'(reg_din_val), 1);
    check_eq("latency_din", int'(reg_din), 8'hA5);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
`ifdef SPI_CFG_SEQ_STATS_EN
    check_eq("stat_clear", int'(stat_done_cnt) + int'(stat_fail_cnt) + int'(stat_retry_cnt), 0);
`endif
    tick();
    rst = 1'b0;
    reg_ack = 1'b1;
    stray = 0;
    quiet_tick();
    reg_ack = 1'b0;
    repeat (3) quiet_tick();
    check_eq("late_ack_ignored", stray, 0);
    check_eq("late_ack_idle", int'(idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_cfg_seq.md
Name: spi_slave_cfg_seq

Overview:
Configuration sequencer for the SPI slave core's register-configuration port. Accepts register words from the host into a 4-deep request queue. Issues each word to the slave only while no SPI transaction is in progress, waits for ack/err, retries failures and reports completion or error. Sits between the host and the slave's config interface (reg_din / reg_din_val / reg_ack / reg_err).

Parameters:
REG_W, 8, register word width (equals reg_din_width_c)
QDEPTH, 4, request queue depth (power of 2, ≥2)
MAX_RETRY, 3, re-issues after a failure before the word is dropped
TIMEOUT_CYC, 16, cycles to wait for ack/err after issue

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cfg_data  in  REG_W  host register word
cfg_wr  in  1  push cfg_data into the queue
cfg_full  out  1  queue full
cfg_empty  out  1  queue empty
spi_busy  in  1  slave core busy (a transaction is active)
reg_din  out  REG_W  word to slave
reg_din_val  out  1  single-cycle issue strobe
reg_ack  in  1  slave accepted the word
reg_err  in  1  slave rejected the word
cfg_done  out  1  one-cycle pulse: word acked
cfg_fail  out  1  one-cycle pulse: word dropped after retries exhausted
cfg_ovf  out  1  one-cycle pulse: push lost because the queue was full
idle  out  1  state IDLE and queue empty

Behaviour:
- Reset (asynchronous): FSM=IDLE; queue empty; retry and timer counters=0.
  - Outputs: reg_din=0, reg_din_val=0, cfg_done/fail/ovf=0, cfg_full=0, cfg_empty=1, idle=1.
- Reset mid-operation discards the queue and the in-flight word. Late ack/err after reset are ignored because the FSM is in IDLE.
- Queue:
  - Push on cfg_wr && !cfg_full. Push while full: data dropped, cfg_ovf pulses the next cycle. The full check uses the registered flag, so a same-cycle pop does not rescue the push.
  - Pointers wrap modulo QDEPTH. Count width is clog2(QDEPTH)+1.
- FSM states:
  - IDLE: if !cfg_empty → WAIT_BUSY.
  - WAIT_BUSY: if !spi_busy → ISSUE. Otherwise hold with no timeout.
  - ISSUE: reg_din <= queue head (registered); reg_din_val=1 for exactly 1 cycle; timer cleared → WAIT_RESP.
    - The queue head is not popped until the word is resolved.
  - WAIT_RESP, timer increments each cycle:
    - reg_ack && !reg_err → pop; cfg_done pulse; retry=0 → IDLE.
    - reg_err (including simultaneous ack+err, where err wins) or timer==TIMEOUT_CYC-1 → failure.
    - On failure: if retry<MAX_RETRY then retry+1 → WAIT_BUSY. Otherwise pop; cfg_fail pulse; retry=0 → IDLE.
- Latency: queue non-empty with spi_busy=0 → reg_din_val asserted 2 cycles after the push (push→IDLE sees non-empty, →WAIT_BUSY, →ISSUE).
- reg_din holds its last issued value between issues.
- reg_ack/reg_err outside WAIT_RESP are ignored.
- spi_busy rising while in WAIT_RESP has no effect.
- A word is issued at most 1+MAX_RETRY times.

Optional Feature:
SPI_CFG_SEQ_STATS_EN
- Defined: adds outputs stat_done_cnt[15:0], stat_fail_cnt[15:0] and stat_retry_cnt[15:0].
  - Each counts cfg_done, cfg_fail and retry events respectively.
  - Each saturates at 16'hFFFF.
  - All clear on rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package spi_slave_cfg_pkg holds:
  - state enum cfg_seq_state_t {IDLE, WAIT_BUSY, ISSUE, WAIT_RESP};
  - reg_din_width_c;
  - default constants for QDEPTH, MAX_RETRY and TIMEOUT_CYC.
- One sub-module, spi_cfg_req_fifo: a synchronous FIFO of QDEPTH×REG_W with push/pop/full/empty and an overflow pulse. The sequencer FSM and counters stay in the top module.

Test Plan:
- Push 8'hA5 with spi_busy=0, slave acks 3 cycles after reg_din_val → reg_din=8'hA5, a single reg_din_val pulse, cfg_done pulse, idle=1.
- Push 8'h11 with spi_busy=1 for 20 cycles → no reg_din_val while busy; issue occurs 1 cycle after busy falls; no timeout.
- Slave answers reg_err to every issue of 8'h3C → exactly 4 reg_din_val pulses, 1 cfg_fail, queue empty, retry=0.
- Slave silent → each attempt times out after 16 cycles; after 4 attempts cfg_fail; stat_fail_cnt=1 when SPI_CFG_SEQ_STATS_EN is defined.
- Push 5 words back-to-back with the slave stalled → cfg_full after the 4th push; the 5th push is dropped with a cfg_ovf pulse; 4 words are later issued in FIFO order.
- Assert rst during WAIT_RESP, then send reg_ack → all outputs at reset values; ack ignored; no cfg_done.
- Simultaneous reg_ack and reg_err → treated as error, a retry is issued, no cfg_done.
